// File: rtl/seq_divider.sv
// seq_divider: iterative unsigned restoring divider, one quotient bit per clock.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, CALC} state_e;
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] wrem_q, wrem_d, wq_q, wq_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
  logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  logic [WIDTH:0]   shifted, trial;
  assign shifted = {wrem_q, wq_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wrem_d  = wrem_q;
    wq_d    = wq_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    if (state_q == IDLE) begin
      if (start) begin
        dvs_d = divisor;
        if (divisor != '0) begin
          state_d = CALC;
          busy_d  = 1'b1;
          cnt_d   = CW'(WIDTH);
          wrem_d  = '0;
          wq_d    = dividend;
        end else begin
          done_d = 1'b1;
          dbz_d  = 1'b1;
          quot_d = '1;
          rem_d  = dividend;
        end
      end
    end else begin
      // Negative trial (MSB set) restores the shifted partial remainder.
      wrem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      wq_d   = {wq_q[WIDTH-2:0], ~trial[WIDTH]};
      cnt_d  = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        dbz_d   = 1'b0;
        quot_d  = wq_d;
        rem_d   = wrem_d;
      end
    end
  end
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wrem_q  <= '0;
      wq_q    <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wrem_q  <= wrem_d;
      wq_q    <= wq_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end
  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and randomized checks of seq_divider against a queued reference.
module tb_seq_divider;
  localparam int W = 8;
  logic         clk = 1'b0, arst = 1'b1, start = 1'b0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;
  int checks = 0, failures = 0, n_push = 0, n_done = 0;
  typedef struct packed {logic [W-1:0] dd; logic [W-1:0] dv;} op_t;
  op_t sb[$];

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .arst(arst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every done must match the oldest accepted request.
  always @(negedge clk) begin
    if (!arst && done) begin
      op_t o;
      n_done++;
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL spurious_done observed=done expected=no_done");
      end
      if (sb.size() != 0) begin
        o = sb.pop_front();
        chk("quotient",    quotient,    (o.dv == 0) ? 32'hFF : 32'(o.dd / o.dv));
        chk("remainder",   remainder,   (o.dv == 0) ? 32'(o.dd) : 32'(o.dd % o.dv));
        chk("div_by_zero", div_by_zero, (o.dv == 0) ? 32'd1 : 32'd0);
      end
    end
  end

  task automatic accept(input logic [W-1:0] dd, input logic [W-1:0] dv, input bit push);
    start = 1'b1;
    dividend = dd;
    divisor = dv;
    if (push) begin
      sb.push_back({dd, dv});
      n_push++;
    end
    @(negedge clk);
    start = 1'b0;
    dividend = W'($urandom);
    divisor = W'($urandom);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  logic [W-1:0] dd, dv;
  int n;

  initial begin
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quot", quotient, 0);
    chk("rst_rem", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    accept(8'd100, 8'd7, 1);
    for (int i = 0; i < W; i++) begin
      chk("t1_busy", busy, 1);
      chk("t1_done", done, 0);
      @(negedge clk);
    end
    chk("t1_busy_end", busy, 0);
    chk("t1_done_end", done, 1);
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin dd = 8'd255; dv = 8'd1;   end
        1: begin dd = 8'd5;   dv = 8'd200; end
        2: begin dd = 8'd0;   dv = 8'd9;   end
        3: begin dd = 8'd37;  dv = 8'd0;   end
        default: begin dd = 8'd37; dv = 8'd5; end
      endcase
      @(negedge clk);
      accept(dd, dv, 1);
      chk("dir_busy_acc", busy, (dv != 0) ? 1 : 0);
      wait_done(n);
      chk("dir_latency", n, (dv != 0) ? W : 0);
      chk("dir_busy_done", busy, 0);
    end
    @(negedge clk);
    accept(8'd200, 8'd3, 1);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; dividend = 8'd9; divisor = 8'd9;
    @(negedge clk);
    start = 1'b0;
    chk("ign_busy1", busy, 1);
    @(negedge clk);
    start = 1'b1; dividend = 8'd9; divisor = 8'd9;
    @(negedge clk);
    start = 1'b0;
    chk("ign_busy2", busy, 1);
    wait_done(n);
    chk("ign_latency", n, 3);
    accept(8'd9, 8'd9, 1);
    chk("b2b_busy", busy, 1);
    wait_done(n);
    chk("b2b_latency", n, W);
    @(negedge clk);
    accept(8'd250, 8'd6, 0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 arst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_quot", quotient, 0);
    chk("abort_rem", remainder, 0);
    chk("abort_dbz", div_by_zero, 0);
    @(negedge clk);
    arst = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_no_done", n_done, n_push);
    accept(8'd250, 8'd6, 1);
    wait_done(n);
    chk("post_abort_latency", n, W);
    for (int i = 0; i < 1500; i++) begin
      dd = W'($urandom);
      dv = (i % 16 == 0) ? '0 : W'($urandom);
      if (i == 1) begin dd = 8'd255; dv = 8'd255; end
      if (i == 2) begin dd = 8'd0;   dv = 8'd255; end
      if (i == 3) begin dd = 8'd255; dv = 8'd0;   end
      if (i == 4) begin dd = 8'd254; dv = 8'd255; end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      accept(dd, dv, 1);
      wait_done(n);
      chk("sweep_latency", n, (dv != 0) ? W : 0);
    end
    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    chk("done_count", n_done, n_push);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
